// File: rtl/apb_chk_pkg.sv
// Shared types for the APB3 protocol checker: bus phase, violation codes and
// a helper that reports the lowest-numbered violation of a cycle.
package apb_chk_pkg;

    localparam int NUM_VIOL = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } phase_t;

    typedef enum logic [2:0] {
        NONE           = 3'd0,
        SETUP_VIOL     = 3'd1,
        ENABLE_MISSING = 3'd2,
        CTRL_UNSTABLE  = 3'd3,
        ABORT          = 3'd4,
        STRAY_ENABLE   = 3'd5
    } viol_code_t;

    // Bit k-1 of the vector stands for code k; the lowest set bit wins.
    function automatic viol_code_t lowest_code(input logic [NUM_VIOL-1:0] v);
        viol_code_t c;
        c = NONE;
        for (int unsigned k = NUM_VIOL; k > 0; k--) begin
            if (v[k-1]) c = viol_code_t'(3'(k));
        end
        return c;
    endfunction

endpackage

// File: rtl/apb_sat_counter.sv
// Saturating statistics counter with synchronous clear; an increment in the
// clearing cycle leaves the count at 1.
module apb_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && count != '1) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3 monitor: classifies each bus cycle against the phase seen in
// the previous cycle, flags protocol violations and counts completions.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic                  clr,
    output logic                  viol_pulse,
    output logic [2:0]            viol_code,
    output logic [NUM_VIOL-1:0]   viol_vec,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  viol_cnt
);

    phase_t                st, st_next;
    viol_code_t            code_q;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  cap_write;
    logic                  cap_load;
    logic                  complete;
    logic                  comp_write;
    logic                  unstable;
    logic [NUM_VIOL-1:0]   viol;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            st <= IDLE;
        end else begin
            st <= st_next;
        end
    end

    always_comb begin
        st_next    = st;
        cap_load   = 1'b0;
        complete   = 1'b0;
        comp_write = cap_write;
        viol       = '0;
        unstable   = (PADDR != cap_addr) || (PWRITE != cap_write) ||
                     (PWRITE && (PWDATA != cap_wdata));
        case (st)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    cap_load = 1'b1;
                    st_next  = SETUP;
                end else if (PSEL && PENABLE) begin
                    // Setup skipped: this cycle's control is the reference.
                    viol[0]    = 1'b1;
                    cap_load   = 1'b1;
                    comp_write = PWRITE;
                    complete   = PREADY;
                    st_next    = PREADY ? IDLE : ACCESS;
                end else if (PENABLE) begin
                    viol[4] = 1'b1;
                end
            end
            SETUP: begin
                if (PSEL && PENABLE) begin
                    viol[2]  = unstable;
                    complete = PREADY;
                    st_next  = PREADY ? IDLE : ACCESS;
                end else if (PSEL) begin
                    viol[1]  = 1'b1;
                    cap_load = 1'b1;
                end else begin
                    viol[3] = 1'b1;
                    st_next = IDLE;
                end
            end
            ACCESS: begin
                if (PSEL && PENABLE) begin
                    viol[2]  = unstable;
                    complete = PREADY;
                    st_next  = PREADY ? IDLE : ACCESS;
                end else begin
                    viol[3] = 1'b1;
                    st_next = IDLE;
                end
            end
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_write  <= 1'b0;
            viol_pulse <= 1'b0;
            code_q     <= NONE;
            viol_vec   <= '0;
        end else begin
            if (cap_load) begin
                cap_addr  <= PADDR;
                cap_wdata <= PWDATA;
                cap_write <= PWRITE;
            end
            viol_pulse <= |viol;
            if (|viol) code_q <= lowest_code(viol);
            viol_vec <= (clr ? '0 : viol_vec) | viol;
        end
    end

    assign viol_code = code_q;

    apb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk(PCLK), .rst(PRESET), .inc(complete && comp_write),
        .clr(clr), .count(wr_cnt)
    );

    apb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk(PCLK), .rst(PRESET), .inc(complete && !comp_write),
        .clr(clr), .count(rd_cnt)
    );

    apb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk(PCLK), .rst(PRESET), .inc(complete && PSLVERR),
        .clr(clr), .count(err_cnt)
    );

    apb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_viol_cnt (
        .clk(PCLK), .rst(PRESET), .inc(|viol),
        .clr(clr), .count(viol_cnt)
    );

endmodule

// File: doc/apb_protocol_checker.md
Name: apb_protocol_checker

Overview:
- Passive APB3 bus checker that sits directly downstream of the testbench APB driver, in parallel with the APB slave.
- Samples PSEL/PENABLE/PADDR/PWRITE/PWDATA/PREADY/PSLVERR every PCLK edge.
- Tracks transfer phase and flags protocol violations, including the PSEL setup violation the driver can inject.
- Keeps transfer, error and violation counters for scoreboard cross-check.

Parameters:
- ADDR_WIDTH, 8, PADDR width
- DATA_WIDTH, 32, PWDATA width
- CNT_WIDTH, 16, width of every statistics counter

Ports:
- PCLK  in  1  bus clock, all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase enable
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_WIDTH  address
- PWDATA  in  DATA_WIDTH  write data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error, valid when PREADY=1 in access
- clr  in  1  synchronous clear of sticky flags and counters
- viol_pulse  out  1  one-cycle pulse, violation seen in previous cycle
- viol_code  out  3  code of that violation, held until next violation
- viol_vec  out  5  sticky flags, bit k-1 = code k seen
- wr_cnt  out  CNT_WIDTH  completed writes
- rd_cnt  out  CNT_WIDTH  completed reads
- err_cnt  out  CNT_WIDTH  completions with PSLVERR=1
- viol_cnt  out  CNT_WIDTH  cycles with at least one violation

Behaviour:
- Reset: st=IDLE; all outputs 0; captured control cleared. Reset mid-transfer abandons it; no count, no flag.
- st records the phase of the previous cycle: IDLE, SETUP or ACCESS (wait). The current cycle is classified against st.
- st=IDLE:
  - PSEL=1, PENABLE=0: legal setup. Capture PADDR/PWRITE/PWDATA; next SETUP.
  - PSEL=1, PENABLE=1: code 1 SETUP_VIOL. Capture control. If PREADY=1, count completion and go to IDLE; otherwise go to ACCESS.
  - PSEL=0, PENABLE=1: code 5 STRAY_ENABLE; stay IDLE.
- st=SETUP:
  - PSEL=1, PENABLE=1: access cycle. Compare against captured control (PWDATA only when PWRITE=1); any mismatch is code 3 CTRL_UNSTABLE. If PREADY=1, complete and go to IDLE; otherwise go to ACCESS.
  - PSEL=1, PENABLE=0: code 2 ENABLE_MISSING. Recapture control; stay SETUP.
  - PSEL=0: code 4 ABORT; go to IDLE.
- st=ACCESS:
  - PSEL=1, PENABLE=1: stability check (code 3); complete on PREADY=1.
  - Any other combination: code 4 ABORT; go to IDLE; not counted.
- Back-to-back: a completion returns st to IDLE, so PSEL held high with PENABLE low next cycle is a legal setup.
- Completion: increments wr_cnt or rd_cnt from captured PWRITE; increments err_cnt if PSLVERR=1.
- Multiple codes in one cycle: all set their viol_vec bits; viol_code reports the lowest code; viol_cnt increments once.
- Output timing: all outputs are registered, with one-cycle latency from the sampled edge.
- Counters: saturate at all-ones; no wrap.
- clr: zeroes viol_vec and all counters. A violation or completion in the same cycle wins, giving the new bit set or a count of 1. viol_code is not cleared.

Decomposition:
- Package apb_chk_pkg holds:
  - phase_t enum {IDLE, SETUP, ACCESS}
  - viol_code_t enum: NONE=0, SETUP_VIOL=1, ENABLE_MISSING=2, CTRL_UNSTABLE=3, ABORT=4, STRAY_ENABLE=5
  - constant NUM_VIOL=5
- One sub-module, apb_sat_counter (CNT_WIDTH; inc, clr), instantiated four times.

Test Plan:
- Zero-wait write addr 0x10 data 0xA5A50001, then zero-wait read addr 0x10 -> wr_cnt=1, rd_cnt=1, viol_vec=0, viol_pulse never high.
- PSEL and PENABLE rise on the same edge, addr 0x20, PREADY=1 -> viol_pulse=1 one cycle later, viol_code=1, viol_vec=5'b00001, wr_cnt=1, viol_cnt=1.
- Write with PREADY low 3 cycles, PADDR changes 0x30->0x34 in the 2nd wait cycle -> viol_code=3, viol_vec[2]=1, completion still counted.
- PSEL dropped during a wait state -> viol_code=4, no count; next clean setup accepted with no flag.
- PRESET asserted mid-ACCESS, then PSEL=1/PENABLE=1 on the first cycle after release -> all outputs 0 during reset, then viol_code=1.
- clr coincident with a code-5 cycle, with viol_vec=5'b00101 beforehand -> viol_vec=5'b10000, viol_cnt=1. Separately, CNT_WIDTH=4 with 17 writes -> wr_cnt=15.
